dbg_loader: RTL and testbench
=============================

# dbg_loader

Debug/load controller that gives a host hardware access to the pipeline's instruction memory, data memory and register file, and controls the pipeline run enable with a PC breakpoint. It accepts burst commands over valid/ready channels and streams write data in and read data out. It drives the pipeline's `pipe_en`, `imem_*`, `dmem_*` and `reg_*` debug ports. It replaces simulation-only load, dump and run-until-PC sequencing with synthesizable, parametrised logic.

## Interface
- `IMEM_AW`, 9, IMEM address width
- `IMEM_DW`, 32, IMEM word width
- `DMEM_AW`, 8, DMEM address width
- `REG_AW`, 4, register file address width
- `DATA_W`, 64, host data width and DMEM/REG word width; must be ≥ IMEM_DW
- `PC_W`, 9, PC width
- `LEN_W`, 10, burst length width
- `RD_LAT`, 1, wait cycles between address launch and memory output sampling; legal range 0..3
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-high
- `cmd_valid`, `cmd_ready` in/out 1: command handshake
- `cmd_op` in 3: 0 NOP, 1 WR_IMEM, 2 WR_DMEM, 3 RD_IMEM, 4 RD_DMEM, 5 RD_REG, 6 RUN, 7 HALT
- `cmd_addr` in 16: start address (truncated to the target AW); for RUN, the breakpoint (truncated to PC_W)
- `cmd_len` in LEN_W: word count
- `wr_valid`, `wr_ready` in/out 1; `wr_data` in DATA_W: write beat channel
- `rd_valid` out 1, `rd_ready` in 1, `rd_data` out DATA_W: read beat channel
- `done` out 1: one-cycle pulse when a command completes
- `busy` out 1: high when the FSM is not in IDLE
- `bp_hit` out 1: breakpoint reached
- `pipe_en` out 1: pipeline run enable
- `PC` in PC_W: pipeline program counter
- `imem_addr` out IMEM_AW, `imem_data` out IMEM_DW, `imem_we` out 1, `imem_re` out 1, `imem_out` in IMEM_DW: IMEM port
- `dmem_addr` out DMEM_AW, `dmem_data` out DATA_W, `dmem_we` out 1, `dmem_re` out 1, `dmem_out` in DATA_W: DMEM port
- `reg_addr` out REG_AW, `reg_re` out 1, `reg_out` in DATA_W: register file read port

## Operation
- **States:** IDLE, WR, RD_ISSUE, RD_WAIT, RD_OUT, RUN.
- **IDLE command acceptance:** `cmd_ready` = 1 in IDLE. In RUN, `cmd_ready` = 1 only when `cmd_op`==HALT. In all other states `cmd_ready` = 0.
- **Accept:** a command is accepted on `cmd_valid & cmd_ready`. On accept, the FSM latches op, address and length, and clears `bp_hit`.
- **NOP, HALT in IDLE, and any command with `cmd_len`==0 (except RUN):**
  - Return to IDLE.
  - `done` pulses in the cycle after accept.
  - No memory strobes are issued.
- **WR_IMEM / WR_DMEM:**
  - In WR, `wr_ready` = 1.
  - On each beat handshake, the controller registers the address, data and a one-cycle `*_we` strobe.
  - `imem_data` = `wr_data[IMEM_DW-1:0]`.
  - The address increments modulo 2^AW after each beat.
  - After the last beat, the FSM goes to IDLE. `done` pulses in the same cycle as the final `*_we`.
- **Reads (RD_IMEM / RD_DMEM / RD_REG):**
  - RD_ISSUE drives the address with a one-cycle `*_re` strobe.
  - RD_WAIT holds for RD_LAT cycles, using a counter.
  - At the end of the last wait cycle, the memory output is captured into `rd_data`. IMEM data is zero-extended to DATA_W.
  - RD_OUT holds `rd_valid` = 1, with `rd_data` stable, until `rd_ready` is high.
  - The address increments modulo 2^AW, then the FSM returns to RD_ISSUE or, after the last word, to IDLE with a `done` pulse.
  - With RD_LAT=0, the capture happens at the end of the issue cycle.
- **RUN:**
  - Breakpoint `bp` = `cmd_addr[PC_W-1:0]`.
  - If `PC` ≥ `bp` at accept: `pipe_en` stays 0, `bp_hit` = 1, and `done` pulses in the next cycle.
  - Otherwise, `pipe_en` = 1 from the cycle after accept.
  - Each cycle in RUN, if `PC` ≥ `bp` (unsigned compare): `pipe_en` goes to 0, `bp_hit` = 1, `done` pulses, and the FSM goes to IDLE, all on the next edge.
- **HALT accepted in RUN:** `pipe_en` = 0, `bp_hit` = 0, and `done` pulses, all on the next edge.
- **Simultaneous breakpoint and HALT:** the breakpoint has priority, so `bp_hit` = 1.
- **Memory access during run:** memory and register commands are never issued while `pipe_en` = 1.
- **Illegal ops:** none exist; all eight encodings are defined.

## Timing
- All outputs are registered except `cmd_ready` and `wr_ready`, which decode the state combinationally.
- **Reset:** all outputs = 0 and the state is IDLE, so `cmd_ready` = 1 once reset is released.
- **Reset mid-operation:** strobes, `pipe_en`, `rd_valid` and `done` drop immediately (asynchronously). The burst in progress is abandoned and is not resumed.
- **Write throughput:** 1 word/cycle. `*_we` trails each beat handshake by one edge.
- **Read cycle:** RD_LAT+2 cycles per word minimum (issue, wait(s), out), plus any `rd_ready` stall.
- **Break latency:** `pipe_en` falls on the edge after the cycle in which `PC` ≥ `bp` is first seen.
- **`busy`:** high from the edge after accept through the cycle before `done`; low in the `done` cycle.

## Test plan
- WR_IMEM at addr 0, len 4, data 0xA,0xB,0xC,0xD with `wr_valid` held high -> `imem_we` high for 4 consecutive cycles at addresses 0..3 with matching data; `done` pulses with the 4th `we`.
- RD_DMEM at addr 254, len 3, RD_LAT=1, with `rd_ready` held low for 3 cycles on the first word -> addresses 254,255,0 (wrap); `rd_data` matches the memory model and stays stable while stalled; `done` pulses after the 3rd beat.
- RUN with bp=47 and a PC model counting up from 0 -> `pipe_en` rises the cycle after accept and falls the cycle after PC=47; `bp_hit`=1; one `done` pulse.
- RUN with bp=47 while PC=50 -> `pipe_en` never rises; `bp_hit`=1; `done` pulses one cycle after accept.
- HALT issued while in RUN at PC=20, bp=47 -> `pipe_en`=0 the next cycle; `bp_hit`=0; `done` pulses; subsequent RD_REG at addr 15, len 1 returns `reg_out`.
- `reset` asserted during the 2nd beat of a len-8 DMEM write -> `dmem_we` drops immediately; after release, `cmd_ready`=1; a WR_IMEM with len 0 -> `done` pulses one cycle after accept with no `imem_we`.

Source files
------------

// File: rtl/dbg_loader.sv
// dbg_loader: host debug/load controller for pipeline IMEM, DMEM, register file and run control
//   clk, reset               : clock, asynchronous active-high reset
//   cmd_valid/ready/op/addr/len : burst command channel (addr is breakpoint for RUN)
//   wr_valid/ready/data      : write beat channel, host -> memory
//   rd_valid/ready/data      : read beat channel, memory -> host
//   done, busy, bp_hit       : completion pulse, not-idle flag, breakpoint reached
//   pipe_en, PC              : pipeline run enable and program counter
//   imem_*, dmem_*, reg_*    : pipeline debug memory / register file ports
module dbg_loader #(
    parameter int IMEM_AW = 9,
    parameter int IMEM_DW = 32,
    parameter int DMEM_AW = 8,
    parameter int REG_AW  = 4,
    parameter int DATA_W  = 64,
    parameter int PC_W    = 9,
    parameter int LEN_W   = 10,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [15:0]        cmd_addr,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [DATA_W-1:0]  rd_data,
    output logic               done,
    output logic               busy,
    output logic               bp_hit,
    output logic               pipe_en,
    input  logic [PC_W-1:0]    PC,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [IMEM_DW-1:0] imem_data,
    output logic               imem_we,
    output logic               imem_re,
    input  logic [IMEM_DW-1:0] imem_out,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_data,
    output logic               dmem_we,
    output logic               dmem_re,
    input  logic [DATA_W-1:0]  dmem_out,
    output logic [REG_AW-1:0]  reg_addr,
    output logic               reg_re,
    input  logic [DATA_W-1:0]  reg_out
);
    typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_OUT, RUN} state_t;
    localparam logic [2:0] OP_NOP = 3'd0, OP_WR_IMEM = 3'd1, OP_WR_DMEM = 3'd2, OP_RD_IMEM = 3'd3,
                           OP_RD_DMEM = 3'd4, OP_RD_REG = 3'd5, OP_RUN = 3'd6, OP_HALT = 3'd7;
    state_t state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0] cnt_q, cnt_d;
    logic [PC_W-1:0] bp_q, bp_d;
    logic done_q, done_d, busy_q, bp_hit_q, bp_hit_d, pipe_en_q, pipe_en_d, rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d, dmem_data_q, dmem_data_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [IMEM_DW-1:0] imem_data_q, imem_data_d;
    logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
    logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
    logic imem_we_q, imem_we_d, imem_re_q, imem_re_d, dmem_we_q, dmem_we_d, dmem_re_q, dmem_re_d, reg_re_q, reg_re_d;
    logic issue, capture;
    logic [15:0] issue_addr;
    logic [2:0] issue_op;
    logic unused_ok;

    // Upper address/data bits are deliberately dropped by the narrower targets.
    assign unused_ok = ^{cmd_addr, addr_q, wr_data};
    assign cmd_ready = (state_q == IDLE) || (state_q == RUN && cmd_op == OP_HALT);
    assign wr_ready  = state_q == WR;

    always_comb begin
        state_d = state_q;
        op_d = op_q;
        addr_d = addr_q;
        len_d = len_q;
        cnt_d = cnt_q;
        bp_d = bp_q;
        done_d = 1'b0;
        bp_hit_d = bp_hit_q;
        pipe_en_d = pipe_en_q;
        rd_valid_d = rd_valid_q;
        rd_data_d = rd_data_q;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        imem_we_d = 1'b0;
        imem_re_d = 1'b0;
        dmem_addr_d = dmem_addr_q;
        dmem_data_d = dmem_data_q;
        dmem_we_d = 1'b0;
        dmem_re_d = 1'b0;
        reg_addr_d = reg_addr_q;
        reg_re_d = 1'b0;
        issue = 1'b0;
        issue_addr = addr_q;
        issue_op = op_q;
        capture = (state_q == RD_ISSUE && RD_LAT == 0) || (state_q == RD_WAIT && cnt_q == 2'd0);
        case (state_q)
            IDLE: if (cmd_valid) begin
                op_d = cmd_op;
                addr_d = cmd_addr;
                len_d = cmd_len;
                bp_d = cmd_addr[PC_W-1:0];
                bp_hit_d = 1'b0;
                if (cmd_op == OP_RUN) begin
                    // Already at or past the breakpoint: never enable the pipeline.
                    if (PC >= cmd_addr[PC_W-1:0]) begin
                        bp_hit_d = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        pipe_en_d = 1'b1;
                        state_d = RUN;
                    end
                end else if (cmd_op == OP_NOP || cmd_op == OP_HALT || cmd_len == '0) begin
                    done_d = 1'b1;
                end else if (cmd_op == OP_WR_IMEM || cmd_op == OP_WR_DMEM) begin
                    state_d = WR;
                end else begin
                    issue = 1'b1;
                    issue_addr = cmd_addr;
                    issue_op = cmd_op;
                end
            end
            WR: if (wr_valid) begin
                if (op_q == OP_WR_IMEM) begin
                    imem_addr_d = addr_q[IMEM_AW-1:0];
                    imem_data_d = wr_data[IMEM_DW-1:0];
                    imem_we_d = 1'b1;
                end else begin
                    dmem_addr_d = addr_q[DMEM_AW-1:0];
                    dmem_data_d = wr_data;
                    dmem_we_d = 1'b1;
                end
                addr_d = addr_q + 16'd1;
                len_d = len_q - LEN_W'(1);
                if (len_q == LEN_W'(1)) begin
                    state_d = IDLE;
                    done_d = 1'b1;
                end
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
                cnt_d = 2'(RD_LAT - 1);
            end
            RD_WAIT: cnt_d = cnt_q - 2'd1;
            RD_OUT: if (rd_ready) begin
                rd_valid_d = 1'b0;
                addr_d = addr_q + 16'd1;
                len_d = len_q - LEN_W'(1);
                if (len_q == LEN_W'(1)) begin
                    state_d = IDLE;
                    done_d = 1'b1;
                end else begin
                    issue = 1'b1;
                    issue_addr = addr_q + 16'd1;
                end
            end
            RUN: begin
                // Breakpoint wins over a simultaneous HALT.
                if (PC >= bp_q) begin
                    pipe_en_d = 1'b0;
                    bp_hit_d = 1'b1;
                    done_d = 1'b1;
                    state_d = IDLE;
                end else if (cmd_valid && cmd_op == OP_HALT) begin
                    pipe_en_d = 1'b0;
                    bp_hit_d = 1'b0;
                    done_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            rd_data_d = (op_q == OP_RD_IMEM) ? DATA_W'(imem_out) : (op_q == OP_RD_DMEM) ? dmem_out : reg_out;
            rd_valid_d = 1'b1;
            state_d = RD_OUT;
        end
        if (issue) begin
            state_d = RD_ISSUE;
            imem_addr_d = (issue_op == OP_RD_IMEM) ? issue_addr[IMEM_AW-1:0] : imem_addr_q;
            dmem_addr_d = (issue_op == OP_RD_DMEM) ? issue_addr[DMEM_AW-1:0] : dmem_addr_q;
            reg_addr_d = (issue_op == OP_RD_REG) ? issue_addr[REG_AW-1:0] : reg_addr_q;
            imem_re_d = issue_op == OP_RD_IMEM;
            dmem_re_d = issue_op == OP_RD_DMEM;
            reg_re_d = issue_op == OP_RD_REG;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q <= '0;
            addr_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            bp_q <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            bp_hit_q <= 1'b0;
            pipe_en_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q <= '0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            imem_we_q <= 1'b0;
            imem_re_q <= 1'b0;
            dmem_addr_q <= '0;
            dmem_data_q <= '0;
            dmem_we_q <= 1'b0;
            dmem_re_q <= 1'b0;
            reg_addr_q <= '0;
            reg_re_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            addr_q <= addr_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            bp_q <= bp_d;
            done_q <= done_d;
            busy_q <= state_d != IDLE;
            bp_hit_q <= bp_hit_d;
            pipe_en_q <= pipe_en_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q <= rd_data_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            imem_we_q <= imem_we_d;
            imem_re_q <= imem_re_d;
            dmem_addr_q <= dmem_addr_d;
            dmem_data_q <= dmem_data_d;
            dmem_we_q <= dmem_we_d;
            dmem_re_q <= dmem_re_d;
            reg_addr_q <= reg_addr_d;
            reg_re_q <= reg_re_d;
        end
    end

    assign done = done_q;
    assign busy = busy_q;
    assign bp_hit = bp_hit_q;
    assign pipe_en = pipe_en_q;
    assign rd_valid = rd_valid_q;
    assign rd_data = rd_data_q;
    assign imem_addr = imem_addr_q;
    assign imem_data = imem_data_q;
    assign imem_we = imem_we_q;
    assign imem_re = imem_re_q;
    assign dmem_addr = dmem_addr_q;
    assign dmem_data = dmem_data_q;
    assign dmem_we = dmem_we_q;
    assign dmem_re = dmem_re_q;
    assign reg_addr = reg_addr_q;
    assign reg_re = reg_re_q;
endmodule

// File: tb/tb_dbg_loader.sv
// tb_dbg_loader: directed bench for dbg_loader with memory, register file and PC models
module tb_dbg_loader;
    localparam int IMEM_AW = 9, IMEM_DW = 32, DMEM_AW = 8, REG_AW = 4, DATA_W = 64, PC_W = 9, LEN_W = 10, RD_LAT = 1;
    logic clk = 1'b0, reset = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [15:0] cmd_addr = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic wr_valid = 1'b0, wr_ready;
    logic [DATA_W-1:0] wr_data = '0;
    logic rd_valid, rd_ready = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic done, busy, bp_hit, pipe_en;
    logic [PC_W-1:0] pc_cnt, pc_set = '0;
    logic pc_load = 1'b0;
    logic [IMEM_AW-1:0] imem_addr;
    logic [IMEM_DW-1:0] imem_data, imem_out;
    logic imem_we, imem_re;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_data, dmem_out;
    logic dmem_we, dmem_re;
    logic [REG_AW-1:0] reg_addr;
    logic reg_re;
    logic [DATA_W-1:0] reg_out;
    logic [IMEM_DW-1:0] imem_mem [2**IMEM_AW];
    logic [DATA_W-1:0] dmem_mem [2**DMEM_AW];
    logic [DATA_W-1:0] reg_mem [2**REG_AW];
    int checks = 0, passes = 0;

    dbg_loader #(.IMEM_AW(IMEM_AW), .IMEM_DW(IMEM_DW), .DMEM_AW(DMEM_AW), .REG_AW(REG_AW),
                 .DATA_W(DATA_W), .PC_W(PC_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .done(done), .busy(busy), .bp_hit(bp_hit),
        .pipe_en(pipe_en), .PC(pc_cnt), .imem_addr(imem_addr), .imem_data(imem_data), .imem_we(imem_we),
        .imem_re(imem_re), .imem_out(imem_out), .dmem_addr(dmem_addr), .dmem_data(dmem_data), .dmem_we(dmem_we),
        .dmem_re(dmem_re), .dmem_out(dmem_out), .reg_addr(reg_addr), .reg_re(reg_re), .reg_out(reg_out)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous-read memories; contents reload while reset is held.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**IMEM_AW; i++) imem_mem[i] <= '0;
            for (int i = 0; i < 2**DMEM_AW; i++) dmem_mem[i] <= 64'hDA7A_0000_0000_0000 | 64'(i);
            for (int i = 0; i < 2**REG_AW; i++) reg_mem[i] <= 64'h5EED_0000_0000_0000 | 64'(i);
        end else begin
            if (imem_we) imem_mem[imem_addr] <= imem_data;
            if (dmem_we) dmem_mem[dmem_addr] <= dmem_data;
        end
        if (imem_re) imem_out <= imem_mem[imem_addr];
        if (dmem_re) dmem_out <= dmem_mem[dmem_addr];
        if (reg_re) reg_out <= reg_mem[reg_addr];
    end

    always @(posedge clk) begin
        if (pc_load) pc_cnt <= pc_set;
        else if (pipe_en) pc_cnt <= pc_cnt + 1'b1;
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({pipe_en, done, busy, rd_valid, bp_hit} !== 5'b0) $display("FAIL reset_status: got %b want 00000", {pipe_en, done, busy, rd_valid, bp_hit}); else passes++;
        checks++; if ({imem_we, imem_re, dmem_we, dmem_re, reg_re} !== 5'b0) $display("FAIL reset_strobes: got %b want 00000", {imem_we, imem_re, dmem_we, dmem_re, reg_re}); else passes++;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else passes++;
        checks++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", wr_ready); else passes++;
    endtask

    task automatic test_wr_imem();
        logic [31:0] d;
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = 16'd0; cmd_len = 10'd4;
        @(negedge clk);
        cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 64'hA;
        checks++; if (wr_ready !== 1'b1 || busy !== 1'b1) $display("FAIL wr_ready_busy: got %b%b want 11", wr_ready, busy); else passes++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d = 32'hA + 32'(i);
            checks++; if (imem_we !== 1'b1 || imem_addr !== 9'(i) || imem_data !== d) $display("FAIL wr_beat[%0d]: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", i, imem_we, imem_addr, imem_data, i, d); else passes++;
            checks++; if (done !== (i == 3)) $display("FAIL wr_done[%0d]: got %b want %b", i, done, i == 3); else passes++;
            wr_data = 64'hA + 64'(i) + 64'd1;
        end
        wr_valid = 1'b0;
        @(negedge clk);
        checks++; if (imem_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) $display("FAIL wr_after: got we=%b done=%b busy=%b want 000", imem_we, done, busy); else passes++;
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_addr = 16'd2; cmd_len = 10'd1;
        @(negedge clk);
        cmd_valid = 1'b0; rd_ready = 1'b1;
        checks++; if (imem_re !== 1'b1 || imem_addr !== 9'd2) $display("FAIL rdi_issue: got re=%b addr=%0d want re=1 addr=2", imem_re, imem_addr); else passes++;
        repeat (2) @(negedge clk);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 64'h0000_0000_0000_000C) $display("FAIL rdi_data: got valid=%b data=%h want valid=1 data=c", rd_valid, rd_data); else passes++;
        @(negedge clk);
        rd_ready = 1'b0;
        checks++; if (done !== 1'b1 || rd_valid !== 1'b0) $display("FAIL rdi_done: got done=%b valid=%b want 1 0", done, rd_valid); else passes++;
    endtask

    task automatic test_rd_dmem_wrap();
        logic [7:0] ea [3] = '{8'd254, 8'd255, 8'd0};
        logic [63:0] ed [3] = '{64'hDA7A_0000_0000_00FE, 64'hDA7A_0000_0000_00FF, 64'hDA7A_0000_0000_0000};
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_addr = 16'd254; cmd_len = 10'd3; rd_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            checks++; if (dmem_re !== 1'b1 || dmem_addr !== ea[w] || done !== 1'b0) $display("FAIL rdd_issue[%0d]: got re=%b addr=%0d done=%b want re=1 addr=%0d done=0", w, dmem_re, dmem_addr, done, ea[w]); else passes++;
            @(negedge clk);
            checks++; if (rd_valid !== 1'b0 || dmem_re !== 1'b0) $display("FAIL rdd_wait[%0d]: got valid=%b re=%b want 0 0", w, rd_valid, dmem_re); else passes++;
            @(negedge clk);
            checks++; if (rd_valid !== 1'b1 || rd_data !== ed[w]) $display("FAIL rdd_data[%0d]: got valid=%b data=%h want valid=1 data=%h", w, rd_valid, rd_data, ed[w]); else passes++;
            if (w == 0) begin
                repeat (2) begin
                    @(negedge clk);
                    checks++; if (rd_valid !== 1'b1 || rd_data !== ed[0]) $display("FAIL rdd_stall: got valid=%b data=%h want valid=1 data=%h", rd_valid, rd_data, ed[0]); else passes++;
                end
                rd_ready = 1'b1;
            end
        end
        @(negedge clk);
        rd_ready = 1'b0;
        checks++; if (done !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rdd_done: got done=%b valid=%b busy=%b want 1 0 0", done, rd_valid, busy); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL rdd_done_pulse: got %b want 0", done); else passes++;
    endtask

    task automatic test_run_bp();
        int n = 0, dn = 0;
        pc_set = '0; pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd6; cmd_addr = 16'd47; cmd_len = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (pipe_en !== 1'b1 || busy !== 1'b1 || bp_hit !== 1'b0) $display("FAIL run_start: got pipe_en=%b busy=%b bp_hit=%b want 1 1 0", pipe_en, busy, bp_hit); else passes++;
        while (pipe_en === 1'b1 && n < 200) begin
            if (done) dn++;
            n++;
            @(negedge clk);
        end
        checks++; if (n != 48) $display("FAIL run_cycles: got %0d want 48", n); else passes++;
        checks++; if (pc_cnt !== 9'd48) $display("FAIL run_pc_stop: got %0d want 48", pc_cnt); else passes++;
        checks++; if (bp_hit !== 1'b1 || done !== 1'b1 || dn != 0 || busy !== 1'b0) $display("FAIL run_end: got bp_hit=%b done=%b early_done=%0d busy=%b want 1 1 0 0", bp_hit, done, dn, busy); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0 || pipe_en !== 1'b0) $display("FAIL run_after: got done=%b pipe_en=%b want 0 0", done, pipe_en); else passes++;
    endtask

    task automatic test_nop();
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_addr = 16'd3; cmd_len = 10'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (done !== 1'b1 || bp_hit !== 1'b0 || busy !== 1'b0) $display("FAIL nop: got done=%b bp_hit=%b busy=%b want 1 0 0", done, bp_hit, busy); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL nop_pulse: got %b want 0", done); else passes++;
    endtask

    task automatic test_run_immediate();
        pc_set = 9'd50; pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd6; cmd_addr = 16'd47; cmd_len = 10'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (pipe_en !== 1'b0 || bp_hit !== 1'b1 || done !== 1'b1 || busy !== 1'b0) $display("FAIL runi: got pipe_en=%b bp_hit=%b done=%b busy=%b want 0 1 1 0", pipe_en, bp_hit, done, busy); else passes++;
        @(negedge clk);
        checks++; if (pipe_en !== 1'b0 || done !== 1'b0) $display("FAIL runi_after: got pipe_en=%b done=%b want 0 0", pipe_en, done); else passes++;
    endtask

    task automatic test_halt_then_reg();
        pc_set = 9'd20; pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd6; cmd_addr = 16'd47; cmd_len = '0;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0;
        #1;
        checks++; if (pipe_en !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL halt_run: got pipe_en=%b cmd_ready=%b want 1 0", pipe_en, cmd_ready); else passes++;
        cmd_op = 3'd7;
        #1;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL halt_ready: got %b want 1", cmd_ready); else passes++;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (pipe_en !== 1'b0 || bp_hit !== 1'b0 || done !== 1'b1 || busy !== 1'b0) $display("FAIL halt: got pipe_en=%b bp_hit=%b done=%b busy=%b want 0 0 1 0", pipe_en, bp_hit, done, busy); else passes++;
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_addr = 16'd15; cmd_len = 10'd1; rd_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (reg_re !== 1'b1 || reg_addr !== 4'd15) $display("FAIL reg_issue: got re=%b addr=%0d want re=1 addr=15", reg_re, reg_addr); else passes++;
        repeat (2) @(negedge clk);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 64'h5EED_0000_0000_000F) $display("FAIL reg_data: got valid=%b data=%h want valid=1 data=5eed00000000000f", rd_valid, rd_data); else passes++;
        @(negedge clk);
        rd_ready = 1'b0;
        checks++; if (done !== 1'b1 || rd_valid !== 1'b0) $display("FAIL reg_done: got done=%b valid=%b want 1 0", done, rd_valid); else passes++;
    endtask

    task automatic test_reset_mid_write();
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_addr = 16'd100; cmd_len = 10'd8;
        @(negedge clk);
        cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 64'h1111;
        @(negedge clk);
        wr_data = 64'h2222;
        checks++; if (dmem_we !== 1'b1 || dmem_addr !== 8'd100 || dmem_data !== 64'h1111) $display("FAIL rst_beat1: got we=%b addr=%0d data=%h want we=1 addr=100 data=1111", dmem_we, dmem_addr, dmem_data); else passes++;
        @(negedge clk);
        checks++; if (dmem_we !== 1'b1 || dmem_addr !== 8'd101 || dmem_data !== 64'h2222) $display("FAIL rst_beat2: got we=%b addr=%0d data=%h want we=1 addr=101 data=2222", dmem_we, dmem_addr, dmem_data); else passes++;
        reset = 1'b1;
        #1;
        checks++; if (dmem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b0) $display("FAIL rst_async: got we=%b busy=%b done=%b wr_ready=%b want 0000", dmem_we, busy, done, wr_ready); else passes++;
        @(negedge clk);
        wr_valid = 1'b0; reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); else passes++;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = 16'd0; cmd_len = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (done !== 1'b1 || imem_we !== 1'b0 || busy !== 1'b0) $display("FAIL len0: got done=%b we=%b busy=%b want 1 0 0", done, imem_we, busy); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0 || imem_we !== 1'b0 || wr_ready !== 1'b0) $display("FAIL len0_after: got done=%b we=%b wr_ready=%b want 000", done, imem_we, wr_ready); else passes++;
    endtask

    initial begin
        test_reset();
        test_wr_imem();
        test_rd_dmem_wrap();
        test_run_bp();
        test_nop();
        test_run_immediate();
        test_halt_then_reg();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
